// File: rtl/reg_display_barrido_pkg.sv
// pkg_display_7seg: shared defaults and counter-width helper for the 7-segment display scan block.
//   N_DIGITS_DEF : default number of digits
//   SCAN_DIV_DEF : default clock cycles per digit slot
//   cnt_w(n)     : width of a counter that holds 0..n-1, never less than one bit
package pkg_display_7seg;

    localparam int N_DIGITS_DEF = 8;
    localparam int SCAN_DIV_DEF = 10000;

    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_display_barrido_contador.sv
// contador_barrido: prescaler plus digit-index counter that paces the display scan.
//   clk_10MHz_i : system clock
//   rst_n_i     : asynchronous active-low reset
//   idx         : digit currently being scanned, 0..N_DIGITS-1
//   fb          : frame boundary, high in the last cycle of the last digit slot
module contador_barrido
    import pkg_display_7seg::*;
#(
    parameter int N_DIGITS = N_DIGITS_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    localparam int IW = cnt_w(N_DIGITS)
) (
    input  logic          clk_10MHz_i,
    input  logic          rst_n_i,
    output logic [IW-1:0] idx,
    output logic          fb
);

    localparam int CW = cnt_w(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = (cnt == CNT_LAST);
    assign fb   = tick && (idx == IDX_LAST);

    // With one digit IDX_LAST is 0, so the wrap branch keeps idx pinned at 0.
    always_ff @(posedge clk_10MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/reg_display_barrido.sv
// reg_display_barrido: double-buffered digit register with tear-free commit and multiplexed anode scan.
//   clk_10MHz_i : system clock
//   rst_n_i     : asynchronous active-low reset
//   we_i/ne_i/d_i : shadow write strobe, per-nibble enables, write data
//   commit_i    : copy shadow to active at the next frame boundary
//   mask_we_i/mask_i : digit-enable mask write (1 = digit lit)
//   d_o         : active register readback
//   busy_o      : commit pending
//   an_o        : active-low anodes, one-hot-low or all ones
//   digit_o     : nibble of the selected digit
//   frame_o     : one-cycle pulse after each frame boundary
module reg_display_barrido
    import pkg_display_7seg::*;
#(
    parameter int N_DIGITS = N_DIGITS_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic                  clk_10MHz_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [N_DIGITS-1:0]   ne_i,
    input  logic [4*N_DIGITS-1:0] d_i,
    input  logic                  commit_i,
    input  logic                  mask_we_i,
    input  logic [N_DIGITS-1:0]   mask_i,
    output logic [4*N_DIGITS-1:0] d_o,
    output logic                  busy_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [3:0]            digit_o,
    output logic                  frame_o
);

    localparam int IW = cnt_w(N_DIGITS);
    localparam int DW = 4 * N_DIGITS;

    logic [DW-1:0]       shadow, shadow_nx, active, wmask;
    logic [N_DIGITS-1:0] mask;
    logic [IW-1:0]       idx;
    logic                fb, pending, copy;

    contador_barrido #(
        .N_DIGITS(N_DIGITS),
        .SCAN_DIV(SCAN_DIV)
    ) u_contador (
        .clk_10MHz_i(clk_10MHz_i),
        .rst_n_i    (rst_n_i),
        .idx        (idx),
        .fb         (fb)
    );

    always_comb begin
        wmask = '0;
        for (int k = 0; k < N_DIGITS; k++)
            wmask[4*k +: 4] = {4{ne_i[k]}};
    end

    // The merged value feeds both the shadow and the copy path, giving write-through on collision.
    assign shadow_nx = we_i ? (shadow & ~wmask) | (d_i & wmask) : shadow;
    assign copy      = fb && (pending || commit_i);
    assign d_o       = active;
    assign busy_o    = pending;

    always_ff @(posedge clk_10MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow  <= '0;
            active  <= '0;
            mask    <= '1;
            pending <= 1'b0;
            frame_o <= 1'b0;
            an_o    <= '1;
            digit_o <= '0;
        end else begin
            shadow  <= shadow_nx;
            if (mask_we_i)
                mask <= mask_i;
            if (copy)
                active <= shadow_nx;
            pending <= !copy && (pending || commit_i);
            frame_o <= fb;
            an_o    <= mask[idx] ? ~(N_DIGITS'(1) << idx) : '1;
            digit_o <= active[4*idx +: 4];
        end
    end

endmodule

// File: tb/tb_reg_display_barrido.sv
// tb_reg_display_barrido: scoreboard bench for reg_display_barrido with N_DIGITS=4, SCAN_DIV=4.
module tb_reg_display_barrido;

    localparam int N = 4;
    localparam int S = 4;
    localparam int F = N * S;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0, commit = 1'b0, mask_we = 1'b0;
    logic [N-1:0]  ne = '0, mask_in = '0;
    logic [4*N-1:0] d_in = '0;
    logic [4*N-1:0] d_out;
    logic          busy, frame;
    logic [N-1:0]  an;
    logic [3:0]    digit;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  an;
        logic [3:0]  dig;
        logic [15:0] d;
        logic        busy;
        logic        frame;
    } exp_t;

    exp_t q[$];

    // reference model state; t counts cycles since reset release (value for the next edge)
    logic [15:0] m_sh, m_act;
    logic [3:0]  m_mask;
    logic        m_pend;
    int          t = 0;

    reg_display_barrido #(.N_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk_10MHz_i(clk),
        .rst_n_i    (rst_n),
        .we_i       (we),
        .ne_i       (ne),
        .d_i        (d_in),
        .commit_i   (commit),
        .mask_we_i  (mask_we),
        .mask_i     (mask_in),
        .d_o        (d_out),
        .busy_o     (busy),
        .an_o       (an),
        .digit_o    (digit),
        .frame_o    (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        exp_t e;
        int slot;
        bit fbm;
        if (!rst_n) begin
            m_sh = '0; m_act = '0; m_mask = '1; m_pend = 1'b0; t = 0;
            e = '{4'hF, 4'h0, 16'h0, 1'b0, 1'b0};
        end else begin
            slot = (t / S) % N;
            fbm = (t % F) == F - 1;
            e.an = m_mask[slot] ? ~(4'b0001 << slot) : 4'hF;
            e.dig = m_act[4*slot +: 4];
            e.frame = fbm;
            for (int k = 0; k < N; k++)
                if (we && ne[k]) m_sh[4*k +: 4] = d_in[4*k +: 4];
            if (fbm && (m_pend || commit)) begin
                m_act = m_sh;
                m_pend = 1'b0;
            end else begin
                m_pend = m_pend | commit;
            end
            if (mask_we) m_mask = mask_in;
            e.d = m_act;
            e.busy = m_pend;
            t++;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("an_o", 32'(an), 32'(e.an));
            chk("digit_o", 32'(digit), 32'(e.dig));
            chk("d_o", 32'(d_out), 32'(e.d));
            chk("busy_o", 32'(busy), 32'(e.busy));
            chk("frame_o", 32'(frame), 32'(e.frame));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] d, input logic [3:0] n_en);
        we = 1'b1; d_in = d; ne = n_en;
        @(negedge clk);
        we = 1'b0; ne = '0;
    endtask

    task automatic wait_phase(input int ph, input string name);
        for (int i = 0; i < 2 * F && (t % F) != ph; i++) @(negedge clk);
        if ((t % F) != ph) chk(name, 32'(t % F), 32'(ph));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(40);
        wr(16'hABCD, 4'b1111);
        wr(16'h0000, 4'b0010);
        idle(3);
        wait_phase(4, "phase_commit");
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        idle(24);
        wait_phase(F - 1, "phase_collide");
        commit = 1'b1; we = 1'b1; d_in = 16'h1234; ne = 4'hF;
        @(negedge clk);
        commit = 1'b0; we = 1'b0; ne = '0;
        idle(5);
        mask_we = 1'b1; mask_in = 4'b0101;
        @(negedge clk);
        mask_we = 1'b0;
        idle(32);
        wait_phase(2, "phase_rst");
        wr(16'h9876, 4'hF);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_d", 32'(d_out), 32'd0);
        chk("rst_an", 32'(an), 32'hF);
        idle(2);
        rst_n = 1'b1;
        wr(16'h5555, 4'hF);
        idle(40);
        for (int i = 0; i < 500; i++) begin
            we = ($urandom % 4) == 0;
            ne = 4'($urandom);
            d_in = 16'($urandom);
            commit = ($urandom % 8) == 0;
            mask_we = ($urandom % 16) == 0;
            mask_in = 4'($urandom);
            @(negedge clk);
        end
        we = 1'b0; commit = 1'b0; mask_we = 1'b0; ne = '0;
        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
